// File: rtl/cut_sweep_sequencer.sv
// cut_sweep_sequencer
// Exhaustive stimulus sequencer for one small combinational circuit-under-test.
// Walks every input vector in ascending order and holds each vector for SETTLE
// cycles. It then captures the CUT outputs, compares them against the expected
// ROM, folds them into a 16-bit MISR and streams each captured beat out over a
// valid/ready interface.
// rst_n asserts asynchronously; its deassertion is expected to arrive already
// synchronised to clk.

module cut_sweep_sequencer #(
    parameter int          N_IN      = 4,
    parameter int          N_OUT     = 10,
    parameter int          SETTLE    = 1,
    parameter logic [15:0] MISR_POLY = 16'h1021,
    parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x,
    input  logic [N_OUT-1:0]  f,
    output logic [N_IN-1:0]   exp_addr,
    input  logic [N_OUT-1:0]  exp_data,
    output logic              cap_valid,
    input  logic              cap_ready,
    output logic [N_IN-1:0]   cap_idx,
    output logic [N_OUT-1:0]  cap_data,
    output logic              cap_err,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [N_IN:0]     mismatch_cnt,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_idx,
    output logic [15:0]       signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } state_t;

    // Settle down-counter counts SETTLE-1 .. 0, so it needs clog2(SETTLE) bits.
    localparam int               CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_IDX    = '1;

    state_t              r_state;
    state_t              w_next;
    logic [N_IN-1:0]     r_idx;
    logic [CW-1:0]       r_settle;

    logic                r_cap_valid;
    logic [N_IN-1:0]     r_cap_idx;
    logic [N_OUT-1:0]    r_cap_data;
    logic                r_cap_err;

    logic                r_aborted;
    logic [N_IN:0]       r_mismatch_cnt;
    logic                r_first_fail_valid;
    logic [N_IN-1:0]     r_first_fail_idx;
    logic [15:0]         r_sig;

    logic                w_start_sweep;
    logic                w_abort;
    logic                w_capture;
    logic                w_handshake;
    logic                w_err;
    logic [15:0]         w_sig_next;

    // Qualified events; abort only counts outside IDLE and beats start/handshake.
    assign w_start_sweep = (r_state == S_IDLE) && start;
    assign w_abort       = (r_state != S_IDLE) && abort;
    assign w_capture     = (r_state == S_CAPTURE) && !abort;
    assign w_handshake   = (r_state == S_EMIT) && cap_ready && !abort;
    assign w_err         = (f != exp_data);
    assign w_sig_next    = {r_sig[14:0], 1'b0}
                         ^ (r_sig[15] ? MISR_POLY : 16'h0000)
                         ^ 16'(f);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort from any busy state overrides the normal flow.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no
        // latch is inferred for w_next.
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_APPLY;
            S_APPLY:   if (r_settle == '0) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_EMIT;
            S_EMIT:    if (cap_ready) w_next = (r_idx == LAST_IDX) ? S_DONE : S_APPLY;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && abort) w_next = S_IDLE;
    end

    // Vector index and settle counter; index returns to 0 whenever the sweep ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_settle <= '0;
        end else if (w_start_sweep) begin
            r_idx    <= '0;
            r_settle <= SETTLE_LOAD;
        end else if (w_abort) begin
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_APPLY: begin
                    if (r_settle != '0) r_settle <= r_settle - CW'(1);
                end
                S_EMIT: begin
                    if (cap_ready && (r_idx != LAST_IDX)) begin
                        r_idx    <= r_idx + N_IN'(1);
                        r_settle <= SETTLE_LOAD;
                    end
                end
                S_DONE:  r_idx <= '0;
                default: ;
            endcase
        end
    end

    // Capture beat: loaded in CAPTURE, held through EMIT until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_data  <= '0;
            r_cap_err   <= 1'b0;
        end else if (w_abort) begin
            r_cap_valid <= 1'b0;
        end else if (w_capture) begin
            r_cap_valid <= 1'b1;
            r_cap_idx   <= r_idx;
            r_cap_data  <= f;
            r_cap_err   <= w_err;
        end else if (w_handshake) begin
            r_cap_valid <= 1'b0;
        end
    end

    // Sweep results: cleared on start, updated per capture, held after the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted          <= 1'b0;
            r_mismatch_cnt     <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
            r_sig              <= MISR_SEED;
        end else if (w_start_sweep) begin
            r_aborted          <= 1'b0;
            r_mismatch_cnt     <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
            r_sig              <= MISR_SEED;
        end else begin
            if (w_abort) r_aborted <= 1'b1;
            if (w_capture) begin
                r_sig <= w_sig_next;
                if (w_err) begin
                    r_mismatch_cnt <= r_mismatch_cnt + (N_IN+1)'(1);
                    if (!r_first_fail_valid) begin
                        r_first_fail_valid <= 1'b1;
                        r_first_fail_idx   <= r_idx;
                    end
                end
            end
        end
    end

    assign x                = r_idx;
    assign exp_addr         = r_idx;
    assign cap_valid        = r_cap_valid;
    assign cap_idx          = r_cap_idx;
    assign cap_data         = r_cap_data;
    assign cap_err          = r_cap_err;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign aborted          = r_aborted;
    assign mismatch_cnt     = r_mismatch_cnt;
    assign first_fail_valid = r_first_fail_valid;
    assign first_fail_idx   = r_first_fail_idx;
    assign signature        = r_sig;

endmodule

// File: tb/tb_cut_sweep_sequencer.sv
// Testbench for cut_sweep_sequencer.
// Two instances: dut (SETTLE=1) with a corruptible expected ROM, and dut3
// (SETTLE=3) with a clean ROM. The bench CUT is f = {0, x}.

module tb_cut_sweep_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int NVEC  = 16;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;
    logic cap_ready;

    logic [N_IN-1:0]  x, exp_addr, cap_idx, first_fail_idx;
    logic [N_OUT-1:0] f, exp_data, cap_data;
    logic             cap_valid, cap_err, busy, done, aborted, first_fail_valid;
    logic [N_IN:0]    mismatch_cnt;
    logic [15:0]      signature;

    logic [N_IN-1:0]  x3, exp_addr3, cap_idx3, first_fail_idx3;
    logic [N_OUT-1:0] f3, exp_data3, cap_data3;
    logic             cap_valid3, cap_err3, busy3, done3, aborted3, first_fail_valid3;
    logic [N_IN:0]    mismatch_cnt3;
    logic [15:0]      signature3;

    logic [N_OUT-1:0] rom [NVEC];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [N_IN-1:0]  idx;
        logic [N_OUT-1:0] data;
        logic             err;
    } beat_t;

    beat_t beats[$];

    typedef struct {
        logic [15:0] corrupt;
        int          ready_mode;
        bit          inj_start;
        int          exp_done;
        int          exp_mm;
        int          exp_ffv;
        int          exp_ffi;
    } vec_t;

    cut_sweep_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x(x), .f(f), .exp_addr(exp_addr), .exp_data(exp_data),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_idx(cap_idx),
        .cap_data(cap_data), .cap_err(cap_err), .busy(busy), .done(done),
        .aborted(aborted), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .signature(signature)
    );

    cut_sweep_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x(x3), .f(f3), .exp_addr(exp_addr3), .exp_data(exp_data3),
        .cap_valid(cap_valid3), .cap_ready(cap_ready), .cap_idx(cap_idx3),
        .cap_data(cap_data3), .cap_err(cap_err3), .busy(busy3), .done(done3),
        .aborted(aborted3), .mismatch_cnt(mismatch_cnt3),
        .first_fail_valid(first_fail_valid3), .first_fail_idx(first_fail_idx3),
        .signature(signature3)
    );

    // Bench CUTs and synchronous expected ROMs.
    assign f  = {6'b0, x};
    assign f3 = {6'b0, x3};

    always @(posedge clk) exp_data  <= rom[exp_addr];
    always @(posedge clk) exp_data3 <= {6'b0, exp_addr3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MISR signature after folding f = 0 .. n-1, from the feedback rule.
    function automatic logic [15:0] misr_model(input int n);
        int s;
        s = 'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = ((s << 1) & 'hFFFF) ^ (((s >> 15) & 1) != 0 ? 'h1021 : 0) ^ i;
        end
        return 16'(s);
    endfunction

    task automatic load_rom(input logic [15:0] corrupt);
        for (int i = 0; i < NVEC; i++)
            rom[i] = corrupt[i] ? (10'(i) ^ 10'h200) : 10'(i);
    endtask

    // Compare collected beats against the first n expected beats of a sweep.
    task automatic check_beats(input string tag, input logic [15:0] corrupt, input int n);
        int nbad;
        logic [15:0] c;
        nbad = 0;
        c = corrupt;
        check({tag, "_beat_count"}, beats.size(), n);
        for (int i = 0; i < beats.size() && i < n; i++) begin
            if (beats[i].idx != 4'(i) || beats[i].data != 10'(i) || beats[i].err != c[i])
                nbad++;
        end
        check({tag, "_beat_content"}, nbad, 0);
    endtask

    // Modes: 0 ready=1, 1 random ready, 2 stall 10 cycles at idx 3,
    // 3 stop at the first EMIT of idx 9 (ready held low there).
    task automatic run_sweep(input int mode, input bit inj_start,
                             output int done_cyc, output int stalls, output int hold_bad);
        int cyc;
        int stall_left;
        bit injected;
        beats.delete();
        done_cyc   = -1;
        stalls     = 0;
        hold_bad   = 0;
        stall_left = 10;
        injected   = 0;
        cap_ready  = 1'b1;
        start      = 1'b1;
        tick();
        cyc = 1;
        while (cyc < 400) begin
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (mode == 3 && cap_valid && cap_idx == 4'd9) begin
                cap_ready = 1'b0;
                done_cyc  = cyc;
                break;
            end
            if (inj_start && !injected && x == 4'd2) begin
                start    = 1'b1;
                injected = 1;
            end
            case (mode)
                1: cap_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (cap_valid && cap_idx == 4'd3 && stall_left > 0) begin
                        cap_ready = 1'b0;
                        stall_left--;
                        if (x != 4'd3 || cap_data != 10'd3) hold_bad++;
                    end else begin
                        cap_ready = 1'b1;
                    end
                end
                default: cap_ready = 1'b1;
            endcase
            if (cap_valid && !cap_ready) stalls++;
            if (cap_valid && cap_ready) beats.push_back('{idx: cap_idx, data: cap_data, err: cap_err});
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_cap_valid"}, cap_valid, 0);
        check({tag, "_cap_idx"}, cap_idx, 0);
        check({tag, "_cap_data"}, cap_data, 0);
        check({tag, "_cap_err"}, cap_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
        check({tag, "_ff_valid"}, first_fail_valid, 0);
        check({tag, "_ff_idx"}, first_fail_idx, 0);
        check({tag, "_signature"}, signature, 16'hFFFF);
        check({tag, "_busy3"}, busy3, 0);
        check({tag, "_signature3"}, signature3, 16'hFFFF);
    endtask

    vec_t vecs[4];

    initial begin
        int done_cyc, stalls, hold_bad, nmm, ffi, ndone, xbad, d3;
        bit found, ffv;
        logic [15:0] corrupt;

        vecs[0] = '{corrupt: 16'h0000, ready_mode: 0, inj_start: 0, exp_done: 49, exp_mm: 0, exp_ffv: 0, exp_ffi: 0};
        vecs[1] = '{corrupt: 16'h1020, ready_mode: 0, inj_start: 0, exp_done: 49, exp_mm: 2, exp_ffv: 1, exp_ffi: 5};
        vecs[2] = '{corrupt: 16'h0000, ready_mode: 2, inj_start: 0, exp_done: 59, exp_mm: 0, exp_ffv: 0, exp_ffi: 0};
        vecs[3] = '{corrupt: 16'h1020, ready_mode: 0, inj_start: 1, exp_done: 49, exp_mm: 2, exp_ffv: 1, exp_ffi: 5};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cap_ready = 1'b1;
        load_rom(16'h0000);
        repeat (3) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // Directed sweeps from the table.
        for (int t = 0; t < 4; t++) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            load_rom(vecs[t].corrupt);
            run_sweep(vecs[t].ready_mode, vecs[t].inj_start, done_cyc, stalls, hold_bad);
            check({tag, "_done_cycle"}, done_cyc, vecs[t].exp_done);
            check_beats(tag, vecs[t].corrupt, NVEC);
            check({tag, "_mismatch_cnt"}, mismatch_cnt, vecs[t].exp_mm);
            check({tag, "_ff_valid"}, first_fail_valid, vecs[t].exp_ffv);
            check({tag, "_ff_idx"}, first_fail_idx, vecs[t].exp_ffi);
            check({tag, "_signature"}, signature, misr_model(NVEC));
            if (vecs[t].ready_mode == 2) check({tag, "_stall_hold"}, hold_bad, 0);
            tick();
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_idle_busy"}, busy, 0);
        end

        // Random ROM corruption and random backpressure against the model.
        for (int r = 0; r < 4; r++) begin
            string tag;
            tag = $sformatf("rnd%0d", r);
            corrupt = 16'($urandom);
            nmm = 0;
            ffv = 0;
            ffi = 0;
            for (int i = 0; i < NVEC; i++) begin
                if (corrupt[i]) begin
                    nmm++;
                    if (!ffv) begin
                        ffv = 1;
                        ffi = i;
                    end
                end
            end
            load_rom(corrupt);
            run_sweep(1, 0, done_cyc, stalls, hold_bad);
            check({tag, "_done_cycle"}, done_cyc, 49 + stalls);
            check_beats(tag, corrupt, NVEC);
            check({tag, "_mismatch_cnt"}, mismatch_cnt, nmm);
            check({tag, "_ff_valid"}, first_fail_valid, ffv);
            check({tag, "_ff_idx"}, first_fail_idx, ffi);
            check({tag, "_signature"}, signature, misr_model(NVEC));
            tick();
        end

        // Abort during APPLY of idx 7.
        load_rom(16'h1020);
        beats.delete();
        cap_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (x == 4'd7 && !cap_valid) begin
                found = 1;
                break;
            end
            if (cap_valid) beats.push_back('{idx: cap_idx, data: cap_data, err: cap_err});
            tick();
        end
        check("abort_reach_idx7", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_x", x, 0);
        check("abort_aborted", aborted, 1);
        check("abort_cap_valid", cap_valid, 0);
        check("abort_done", done, 0);
        check_beats("abort", 16'h1020, 7);
        check("abort_mismatch_cnt", mismatch_cnt, 1);
        check("abort_ff_valid", first_fail_valid, 1);
        check("abort_ff_idx", first_fail_idx, 5);
        check("abort_signature", signature, misr_model(7));
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // A following start clears aborted and the results.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_aborted", aborted, 0);
        check("restart_busy", busy, 1);
        check("restart_mismatch_cnt", mismatch_cnt, 0);
        check("restart_signature", signature, 16'hFFFF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("reabort_busy", busy, 0);
        check("reabort_aborted", aborted, 1);

        // start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 1);
        check("start_abort_aborted", aborted, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // Reset pulsed mid-EMIT of idx 9.
        load_rom(16'h0000);
        run_sweep(3, 0, done_cyc, stalls, hold_bad);
        check("rst_reach_emit9", (done_cyc > 0) && cap_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        tick();
        rst_n = 1'b1;
        cap_ready = 1'b1;
        tick();

        // SETTLE=3 instance: each x held 3 APPLY + CAPTURE + EMIT cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        xbad = 0;
        d3 = -1;
        for (int c = 1; c <= 90; c++) begin
            if (done3 && d3 < 0) d3 = c;
            if (c <= 80) begin
                if (x3 != 4'((c - 1) / 5)) xbad++;
                if (cap_valid3 != (((c - 1) % 5) == 4)) xbad++;
                if (cap_valid3 && (cap_data3 != 10'((c - 1) / 5) || cap_idx3 != 4'((c - 1) / 5) || cap_err3)) xbad++;
            end
            tick();
        end
        check("settle3_done_cycle", d3, 81);
        check("settle3_x_timing", xbad, 0);
        check("settle3_signature", signature3, misr_model(NVEC));
        check("settle3_mismatch_cnt", mismatch_cnt3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
